// File: rtl/risc_pkg.sv
// rtl/risc_pkg.sv - shared types and widths for the RiSC memory arbiter
// Purpose: read-return owner encoding and default bus widths.
// Ports: none (package).
package risc_pkg;

  localparam int RISC_AW = 16;
  localparam int RISC_DW = 16;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2,
    OWN_LD   = 2'd3
  } owner_t;

endpackage

// File: rtl/risc_mem_arbiter_if.sv
// rtl/risc_mem_arbiter_if.sv - one requester port of the RiSC memory arbiter
// Purpose: groups the request/grant/read-return signals of one requester.
// Ports (master = requester side, slave = arbiter side):
//   req, we, addr, wdata : requester -> arbiter, held until gnt
//   gnt                  : arbiter -> requester, same-cycle accept
//   rdata, rvalid        : arbiter -> requester, read data one cycle after grant
interface risc_mem_arbiter_if
  import risc_pkg::*;
#(
  parameter int AW = RISC_AW,
  parameter int DW = RISC_DW
);

  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic [DW-1:0] rdata;
  logic          rvalid;

  modport master (output req, we, addr, wdata, input gnt, rdata, rvalid);
  modport slave  (input req, we, addr, wdata, output gnt, rdata, rvalid);

endinterface

// File: rtl/risc_rr_pick2.sv
// rtl/risc_rr_pick2.sv - two-way round-robin pick for fetch and data ports
// Purpose: chooses between two requesters using a single favour bit.
// Ports:
//   req_a, req_b : requests (a = fetch, b = data)
//   rr           : 0 favours a, 1 favours b
//   inhibit      : suppresses both grants (loader owns the cycle, or reset)
//   gnt          : one-hot grant, bit 0 = a, bit 1 = b
//   rr_next      : favour bit for the next cycle
module risc_rr_pick2 (
  input  logic       req_a,
  input  logic       req_b,
  input  logic       rr,
  input  logic       inhibit,
  output logic [1:0] gnt,
  output logic       rr_next
);

  always_comb begin
    gnt = 2'b00;
    if (!inhibit) begin
      // a wins when alone or when it is favoured; otherwise b if it asks
      if (req_a && (!req_b || !rr)) begin
        gnt = 2'b01;
      end else if (req_b) begin
        gnt = 2'b10;
      end
    end
  end

  // The port just served loses favour; idle and loader cycles keep it.
  always_comb begin
    rr_next = rr;
    if (gnt[0]) begin
      rr_next = 1'b1;
    end else if (gnt[1]) begin
      rr_next = 1'b0;
    end
  end

endmodule

// File: rtl/risc_mem_arbiter.sv
// rtl/risc_mem_arbiter.sv - shares the RiSC single-port memory between fetch, data and loader
// Purpose: one memory operation per cycle; loader has priority but is limited to
//   LD_BURST consecutive grants while fetch or data is waiting; fetch and data
//   share remaining cycles round-robin. Read data returns one cycle after grant.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   if_bus            : instruction fetch requester
//   d_bus             : load/store data requester
//   ld_bus            : loader/debug requester
//   mem_en, mem_we    : memory access strobe and write enable
//   mem_addr, mem_wdata : memory address and write data (0 when idle)
//   mem_rdata         : memory read data, valid the cycle after a read
module risc_mem_arbiter
  import risc_pkg::*;
#(
  parameter int AW       = RISC_AW,
  parameter int DW       = RISC_DW,
  parameter int LD_BURST = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  risc_mem_arbiter_if.slave    if_bus,
  risc_mem_arbiter_if.slave    d_bus,
  risc_mem_arbiter_if.slave    ld_bus,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_wdata,
  input  logic [DW-1:0]        mem_rdata
);

  localparam int RW = $clog2(LD_BURST + 1);

  logic [RW-1:0] ld_run;
  logic          rr;
  owner_t        owner;

  logic          ld_block;
  logic          ld_gnt;
  logic [1:0]    pick;
  logic          rr_next;

  // Loader yields only once it has used its full burst and someone else waits.
  assign ld_block = (ld_run == RW'(LD_BURST)) && (if_bus.req || d_bus.req);
  assign ld_gnt   = rst_n && ld_bus.req && !ld_block;

  risc_rr_pick2 u_pick (
    .req_a   (if_bus.req),
    .req_b   (d_bus.req),
    .rr      (rr),
    .inhibit (ld_gnt || !rst_n),
    .gnt     (pick),
    .rr_next (rr_next)
  );

  assign if_bus.gnt = pick[0];
  assign d_bus.gnt  = pick[1];
  assign ld_bus.gnt = ld_gnt;

  assign mem_en = ld_gnt || pick[0] || pick[1];

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (ld_gnt) begin
      mem_we    = ld_bus.we;
      mem_addr  = ld_bus.addr;
      mem_wdata = ld_bus.wdata;
    end else if (pick[0]) begin
      mem_we    = if_bus.we;
      mem_addr  = if_bus.addr;
      mem_wdata = if_bus.wdata;
    end else if (pick[1]) begin
      mem_we    = d_bus.we;
      mem_addr  = d_bus.addr;
      mem_wdata = d_bus.wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ld_run <= '0;
      rr     <= 1'b0;
      owner  <= OWN_NONE;
    end else begin
      if (ld_gnt) begin
        if (ld_run != RW'(LD_BURST)) begin
          ld_run <= ld_run + 1'b1;
        end
      end else begin
        ld_run <= '0;
      end

      rr <= rr_next;

      if (ld_gnt && !ld_bus.we) begin
        owner <= OWN_LD;
      end else if (pick[0] && !if_bus.we) begin
        owner <= OWN_IF;
      end else if (pick[1] && !d_bus.we) begin
        owner <= OWN_D;
      end else begin
        owner <= OWN_NONE;
      end
    end
  end

  // Gating with rst_n drops the return of a read granted just before reset.
  logic if_rv, d_rv, ld_rv;
  assign if_rv = rst_n && (owner == OWN_IF);
  assign d_rv  = rst_n && (owner == OWN_D);
  assign ld_rv = rst_n && (owner == OWN_LD);

  assign if_bus.rvalid = if_rv;
  assign d_bus.rvalid  = d_rv;
  assign ld_bus.rvalid = ld_rv;
  assign if_bus.rdata  = if_rv ? mem_rdata : '0;
  assign d_bus.rdata   = d_rv  ? mem_rdata : '0;
  assign ld_bus.rdata  = ld_rv ? mem_rdata : '0;

endmodule
